systolic_result_drain: RTL and testbench

//  Downstream stage of the 16x16 int8 systolic array. On a capture request it snapshots the

---
 rtl/gemma_acc_pkg.sv | 15 +
 rtl/systolic_result_drain.sv | 118 +++++++++++
 tb/tb_systolic_result_drain.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gemma_acc_pkg.sv
// Shared constants and drain-FSM encoding for the systolic array accelerator.
// The array dimension, the accumulator width and the state encoding live here so every stage agrees on them.
package gemma_acc_pkg;

  localparam int SA_SIZE        = 16;
  localparam int SA_ACCUM_WIDTH = 32;
  localparam int ROW_W          = SA_SIZE * SA_ACCUM_WIDTH;
  localparam int ROW_IDX_W      = $clog2(SA_SIZE);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } drain_state_t;

endpackage

// File: rtl/systolic_result_drain.sv
// Snapshots the accumulator matrix on capture and releases the array at once.
// The captured rows are then streamed out one per beat on a valid/ready interface.
module systolic_result_drain
  import gemma_acc_pkg::*;
#(
  parameter int SIZE        = SA_SIZE,
  parameter int ACCUM_WIDTH = SA_ACCUM_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               capture_req,
  input  logic [SIZE*SIZE*ACCUM_WIDTH-1:0]   result_matrix,
  output logic                               accum_reset,
  output logic                               busy,
  output logic                               overrun,
  output logic [SIZE*ACCUM_WIDTH-1:0]        m_tdata,
  output logic                               m_tvalid,
  input  logic                               m_tready,
  output logic                               m_tlast,
  output logic [$clog2(SIZE)-1:0]            m_row_idx
);

  localparam int RW = SIZE * ACCUM_WIDTH;
  localparam int IW = $clog2(SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

  drain_state_t r_state;
  drain_state_t w_state_next;

  logic [RW-1:0] r_snap [SIZE];
  logic [RW-1:0] w_in_row [SIZE];
  logic [RW-1:0] r_tdata;
  logic [IW-1:0] r_row_idx;
  logic [IW-1:0] w_idx_inc;
  logic          r_tlast;
  logic          r_accum_reset;
  logic          r_overrun;

  logic w_hs;
  logic w_last_hs;
  logic w_accept;
  logic w_drop;

  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_in_rows
      assign w_in_row[gi] = result_matrix[gi*RW +: RW];
    end
  endgenerate

  assign w_hs      = m_tvalid && m_tready;
  assign w_last_hs = w_hs && (r_row_idx == LAST_IDX);
  // A capture that lands on the final handshake chains straight into the next tile.
  assign w_accept  = capture_req && ((r_state == S_IDLE) || w_last_hs);
  assign w_drop    = capture_req && (r_state == S_DRAIN) && !w_last_hs;
  assign w_idx_inc = r_row_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_DRAIN;
      S_DRAIN: if (w_last_hs && !w_accept) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_idx     <= '0;
      r_tdata       <= '0;
      r_tlast       <= 1'b0;
      r_accum_reset <= 1'b0;
      r_overrun     <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        r_snap[i] <= '0;
      end
    end else begin
      r_accum_reset <= w_accept;
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
      // Row 0 comes straight from the input on the accepting edge so the first beat has no bubble.
      if (w_accept) begin
        for (int i = 0; i < SIZE; i++) begin
          r_snap[i] <= w_in_row[i];
        end
        r_row_idx <= '0;
        r_tdata   <= w_in_row[0];
        r_tlast   <= (SIZE == 1);
      end else if (w_last_hs) begin
        r_row_idx <= '0;
        r_tdata   <= '0;
        r_tlast   <= 1'b0;
      end else if (w_hs) begin
        r_row_idx <= w_idx_inc;
        r_tdata   <= r_snap[w_idx_inc];
        r_tlast   <= (w_idx_inc == LAST_IDX);
      end
    end
  end

  assign busy        = (r_state == S_DRAIN);
  assign m_tvalid    = (r_state == S_DRAIN);
  assign m_tdata     = r_tdata;
  assign m_tlast     = r_tlast;
  assign m_row_idx   = r_row_idx;
  assign accum_reset = r_accum_reset;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: expected beats are queued at capture time.
// A negedge monitor pops the queue on each handshake and also checks that data holds stable during stalls.
module tb_systolic_result_drain;

  localparam int SZ = 16;
  localparam int AW = 32;
  localparam int RW = SZ * AW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              capture_req = 1'b0;
  logic [SZ*RW-1:0]  result_matrix = '0;
  logic              accum_reset;
  logic              busy;
  logic              overrun;
  logic [RW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic              m_tlast;
  logic [3:0]        m_row_idx;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [RW-1:0] data;
    logic          last;
    logic [3:0]    row;
  } beat_t;

  beat_t exp_q[$];

  systolic_result_drain #(.SIZE(SZ), .ACCUM_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .capture_req  (capture_req),
    .result_matrix(result_matrix),
    .accum_reset  (accum_reset),
    .busy         (busy),
    .overrun      (overrun),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .m_row_idx    (m_row_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode 2: negative pattern, mode 3: all ones, otherwise r*256+c offset by mode*0x10000
  function automatic logic [31:0] elem(input int mode, input int r, input int c);
    if (mode == 2) return 32'(-(r*16 + c) - 1);
    if (mode == 3) return 32'hFFFF_FFFF;
    return 32'(r*256 + c + mode*32'h10000);
  endfunction

  task automatic fill(input int mode);
    for (int r = 0; r < SZ; r++)
      for (int c = 0; c < SZ; c++)
        result_matrix[((r*SZ)+c)*AW +: AW] = elem(mode, r, c);
  endtask

  task automatic push_tile(input int mode);
    beat_t b;
    for (int r = 0; r < SZ; r++) begin
      for (int c = 0; c < SZ; c++) b.data[c*AW +: AW] = elem(mode, r, c);
      b.last = (r == SZ-1);
      b.row  = 4'(r);
      exp_q.push_back(b);
    end
  endtask

  // Called at #1 after an edge; returns at #1 after the accepting edge.
  task automatic capture();
    capture_req = 1'b1;
    @(posedge clk); #1;
    capture_req = 1'b0;
  endtask

  task automatic wait_row(input int row);
    int k;
    for (k = 0; k < 100; k++) begin
      if (m_tvalid && (m_row_idx == 4'(row))) break;
      @(posedge clk); #1;
    end
    chk($sformatf("wait_row%0d", row), 32'(k < 100), 32'd1);
  endtask

  // Monitor: scoreboard compare on handshakes plus stall-stability check.
  logic          prev_stall = 1'b0;
  logic [RW-1:0] prev_data;
  logic          prev_last;
  logic [3:0]    prev_row;

  always @(negedge clk) begin
    beat_t e;
    if (prev_stall) begin
      n_checks++;
      if (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last || m_row_idx !== prev_row) begin
        n_errors++;
        $display("FAIL stall_hold: got valid=%0b row=%0d last=%0b required valid=1 row=%0d last=%0b",
                 m_tvalid, m_row_idx, m_tlast, prev_row, prev_last);
      end
    end
    prev_stall = !rst && m_tvalid && !m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    prev_row   = m_row_idx;
    if (!rst && m_tvalid && m_tready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL beat_unexpected: got row=%0d, required no beat", m_row_idx);
      end else begin
        e = exp_q.pop_front();
        if (m_tdata !== e.data || m_tlast !== e.last || m_row_idx !== e.row) begin
          n_errors++;
          $display("FAIL beat: got row=%0d last=%0b data=%h required row=%0d last=%0b data=%h",
                   m_row_idx, m_tlast, m_tdata, e.row, e.last, e.data);
        end else begin
          $display("beat row=%0d last=%0b lane0=%h lane15=%h", m_row_idx, m_tlast,
                   m_tdata[0 +: AW], m_tdata[15*AW +: AW]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit held;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_accum_reset", 32'(accum_reset), 0);
    chk("rst_tlast", 32'(m_tlast), 0);
    chk("rst_row", 32'(m_row_idx), 0);
    chk("rst_tdata_zero", 32'(m_tdata == '0), 1);

    // Basic unstalled drain
    fill(0);
    push_tile(0);
    capture();
    chk("basic_accum_reset_hi", 32'(accum_reset), 1);
    chk("basic_tvalid", 32'(m_tvalid), 1);
    chk("basic_busy", 32'(busy), 1);
    @(posedge clk); #1;
    chk("basic_accum_reset_lo", 32'(accum_reset), 0);
    repeat (15) @(posedge clk);
    #1;
    chk("basic_busy_done", 32'(busy), 0);
    chk("basic_q_empty", 32'(exp_q.size()), 0);

    // Back-pressure with snapshot isolation
    fill(1);
    push_tile(1);
    capture();
    fill(3);
    held = 1'b0;
    for (k = 0; k < 200 && busy; k++) begin
      if (!held && m_row_idx == 4'd7) begin
        m_tready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        held = 1'b1;
        chk("bp_row7_held", 32'(m_row_idx), 7);
        chk("bp_tvalid_held", 32'(m_tvalid), 1);
        m_tready = 1'b1;
      end else begin
        m_tready = (k % 2 == 0);
      end
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    chk("bp_stall_seen", 32'(held), 1);
    chk("bp_busy_done", 32'(busy), 0);
    chk("bp_q_empty", 32'(exp_q.size()), 0);

    // Overrun then back-to-back capture on the last-row handshake
    fill(4);
    push_tile(4);
    capture();
    wait_row(5);
    fill(5);
    capture();
    chk("ovr_overrun", 32'(overrun), 1);
    chk("ovr_no_accum_reset", 32'(accum_reset), 0);
    chk("ovr_row_advanced", 32'(m_row_idx), 6);
    wait_row(15);
    fill(6);
    push_tile(6);
    capture();
    chk("b2b_accum_reset", 32'(accum_reset), 1);
    chk("b2b_tvalid", 32'(m_tvalid), 1);
    chk("b2b_row0", 32'(m_row_idx), 0);
    repeat (16) @(posedge clk);
    #1;
    chk("b2b_busy_done", 32'(busy), 0);
    chk("b2b_overrun_sticky", 32'(overrun), 1);
    chk("b2b_q_empty", 32'(exp_q.size()), 0);

    // Reset mid-drain
    fill(7);
    push_tile(7);
    capture();
    wait_row(9);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_tvalid", 32'(m_tvalid), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_overrun", 32'(overrun), 0);
    exp_q.delete();
    fill(8);
    push_tile(8);
    capture();
    chk("mrst_new_row0", 32'(m_row_idx), 0);
    repeat (16) @(posedge clk);
    #1;
    chk("mrst_busy_done", 32'(busy), 0);

    // Negative values
    fill(2);
    push_tile(2);
    capture();
    repeat (16) @(posedge clk);
    #1;
    chk("neg_busy_done", 32'(busy), 0);
    chk("final_q_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
